dm_access_ctrl: RTL

//  Load/store controller between the CPU MEM stage and the word-only data memory (dm).

---
 rtl/dm_access_pkg.sv | 31 +++
 rtl/dm_lane_align.sv | 39 +++
 rtl/dm_access_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dm_access_pkg.sv
// Shared encodings for the data-memory access controller.
// Size codes, FSM states and the alignment check used by DM_MISALIGN_TRAP_EN.
package dm_access_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        MERGE,
        DONE
    } state_t;

    // Size code 2'b11 behaves as a word.
    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic bad;
        bad = 1'b0;
        if (size == SIZE_HALF)
            bad = lo[0];
        else if (size[1])
            bad = (lo != 2'b00);
        return bad;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte/half lane handling between a 32-bit dm word and the CPU.
// Extracts and extends load lanes, merges store lanes into a read word.
module dm_lane_align
    import dm_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  lane,
    input  logic [31:0] rword,
    input  logic [15:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [7:0]  bsel;
    logic [15:0] hsel;

    always_comb begin
        bsel   = rword[{lane, 3'b000} +: 8];
        hsel   = lane[1] ? rword[31:16] : rword[15:0];
        rdata  = rword;
        merged = rword;
        unique case (1'b1)
            (size == SIZE_BYTE): begin
                rdata = {{24{sign_ext & bsel[7]}}, bsel};
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            (size == SIZE_HALF): begin
                rdata = {{16{sign_ext & hsel[15]}}, hsel};
                merged[{lane[1], 4'b0000} +: 16] = wdata;
            end
            size[1]: begin
                rdata  = rword;
                merged = rword;
            end
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// Load/store controller between the MEM stage and the word-only data memory.
// Define DM_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module dm_access_ctrl
    import dm_access_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_signed,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_stall,
    output logic              cpu_err,
    output logic              DM_enable,
    output logic              DM_read,
    output logic              DM_write,
    output logic [ADDR_W-1:0] DM_address,
    output logic [DATA_W-1:0] DM_in,
    input  logic [DATA_W-1:0] DM_out,
    input  logic              DM_ready
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t          state;
    logic [WD_W-1:0] wd;
    logic            err_q;
    logic [31:0]     rbuf;
    logic [31:0]     ext;
    logic [31:0]     merged;
    logic            trap;
    logic            is_word;

    assign cpu_stall = cpu_req & ~cpu_done;
    assign is_word   = cpu_size[1];

`ifdef DM_MISALIGN_TRAP_EN
    assign trap = misaligned(cpu_size, cpu_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    dm_lane_align u_align (
        .size     (cpu_size),
        .sign_ext (cpu_signed),
        .lane     (cpu_addr[1:0]),
        .rword    (rbuf),
        .wdata    (cpu_wdata[15:0]),
        .rdata    (ext),
        .merged   (merged)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            wd         <= '0;
            err_q      <= 1'b0;
            rbuf       <= '0;
            cpu_rdata  <= '0;
            cpu_done   <= 1'b0;
            cpu_err    <= 1'b0;
            DM_enable  <= 1'b0;
            DM_read    <= 1'b0;
            DM_write   <= 1'b0;
            DM_address <= '0;
            DM_in      <= '0;
        end else begin
            cpu_done  <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
            case (state)
                IDLE: begin
                    // The done cycle still sees the old request held high.
                    if (cpu_req && !cpu_done) begin
                        DM_address <= {cpu_addr[ADDR_W-1:2], 2'b00};
                        wd         <= '0;
                        err_q      <= 1'b0;
                        if (trap) begin
                            err_q <= 1'b1;
                            state <= DONE;
                        end else if (cpu_we && is_word) begin
                            DM_enable <= 1'b1;
                            DM_write  <= 1'b1;
                            DM_in     <= cpu_wdata;
                            state     <= DONE;
                        end else begin
                            DM_enable <= 1'b1;
                            DM_read   <= 1'b1;
                            state     <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    DM_enable <= 1'b0;
                    DM_read   <= 1'b0;
                    state     <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (DM_ready) begin
                        rbuf  <= DM_out;
                        wd    <= '0;
                        state <= cpu_we ? MERGE : DONE;
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        wd    <= '0;
                        state <= DONE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                MERGE: begin
                    DM_enable <= 1'b1;
                    DM_write  <= 1'b1;
                    DM_in     <= merged;
                    state     <= DONE;
                end
                DONE: begin
                    DM_enable <= 1'b0;
                    DM_read   <= 1'b0;
                    DM_write  <= 1'b0;
                    cpu_done  <= 1'b1;
                    cpu_err   <= err_q;
                    cpu_rdata <= (!cpu_we && !err_q) ? ext : '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
